// File: rtl/hsv_binary_filter_pkg.sv
// hsv_binary_filter_pkg: shared constants and helpers for the HSV binary filter
// Contents: HSV_NONE marker, HSV24 field bounds, default tolerances, distance helpers.
package hsv_binary_filter_pkg;
   localparam logic [23:0] HSV_NONE = 24'hFFFFFF;
   localparam int H_MSB = 23, H_LSB = 16, S_MSB = 15, S_LSB = 8, V_MSB = 7, V_LSB = 0;
   localparam logic [7:0] DEF_H_TOL = 8'd8, DEF_S_TOL = 8'd40, DEF_V_TOL = 8'd60;
   localparam int DEF_R = 1;
   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return a > b ? a - b : b - a;
   endfunction
   // hue wraps at 256, so the shorter way round the circle is the distance
   function automatic logic [7:0] hue_dist(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      d = abs_diff(a, b);
      return d > 8'd128 ? 8'(9'd256 - {1'b0, d}) : d;
   endfunction
   function automatic int unsigned popcount(input logic [6:0] v);
      popcount = 0;
      for (int i = 0; i < 7; i++) popcount += 32'(v[i]);
   endfunction
endpackage

// File: rtl/hsv_binary_filter_delay_line.sv
// hsv_binary_filter_delay_line: DEPTH-stage register delay of a WIDTH-bit bus
// Ports: PClk, Rst_n (async, active low), d in, q = d delayed DEPTH cycles.
module hsv_binary_filter_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             PClk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] pipe [DEPTH];
   always_ff @(posedge PClk or negedge Rst_n)
      if (!Rst_n) pipe <= '{default: '0};
      else begin
         pipe[0] <= d;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   assign q = pipe[DEPTH-1];
endmodule

// File: rtl/hsv_binary_filter.sv
// hsv_binary_filter: HSV tolerance match against a per-frame reference plus horizontal majority filter
// Inputs: PClk, Rst_n, VtcHCnt/VtcVCnt/VtcDe timing, HSV24 pixel, HSV_detect reference.
// Outputs: Binary_Raw, Binary_PostProcess and the timing signals, all delayed by L = 3 + R.
module hsv_binary_filter
   import hsv_binary_filter_pkg::*;
#(
   parameter logic [7:0] H_TOL = DEF_H_TOL,
   parameter logic [7:0] S_TOL = DEF_S_TOL,
   parameter logic [7:0] V_TOL = DEF_V_TOL,
   parameter int         R     = DEF_R
) (
   input  logic        PClk,
   input  logic        Rst_n,
   input  logic [11:0] VtcHCnt,
   input  logic [11:0] VtcVCnt,
   input  logic        VtcDe,
   input  logic [23:0] HSV24,
   input  logic [23:0] HSV_detect,
   output logic        Binary_Raw,
   output logic        Binary_PostProcess,
   output logic [11:0] VtcHCnt_o,
   output logic [11:0] VtcVCnt_o,
   output logic        VtcDe_o
);
   localparam int L = 3 + R;
   logic [23:0] ref_q, cur_ref;
   logic [7:0] dh, ds, dv;
   logic de1, vld1, de2, match, de_c;
   logic [2*R-1:0] win;
   logic [24:0] ctr_o;
   // the frame-origin pixel already uses the freshly sampled reference
   assign cur_ref = (VtcVCnt == '0 && VtcHCnt == '0) ? HSV_detect : ref_q;
   always_ff @(posedge PClk or negedge Rst_n)
      if (!Rst_n) begin
         ref_q <= HSV_NONE;
         dh <= '0;
         ds <= '0;
         dv <= '0;
         vld1 <= 1'b0;
         de1 <= 1'b0;
         de2 <= 1'b0;
         match <= 1'b0;
         win <= '0;
         Binary_PostProcess <= 1'b0;
      end else begin
         ref_q <= cur_ref;
         dh <= hue_dist(HSV24[H_MSB:H_LSB], cur_ref[H_MSB:H_LSB]);
         ds <= abs_diff(HSV24[S_MSB:S_LSB], cur_ref[S_MSB:S_LSB]);
         dv <= abs_diff(HSV24[V_MSB:V_LSB], cur_ref[V_MSB:V_LSB]);
         vld1 <= cur_ref != HSV_NONE;
         de1 <= VtcDe;
         de2 <= de1;
         match <= de1 & vld1 & (dh <= H_TOL) & (ds <= S_TOL) & (dv <= V_TOL);
         // keep draining the line tail until the centre leaves DE, then clear so taps never span lines
         win <= (!de2 && !de_c) ? '0 : {win[2*R-2:0], match};
         Binary_PostProcess <= (int'(popcount(7'({win, match}))) >= R + 1) & de_c;
      end
   hsv_binary_filter_delay_line #(.WIDTH(1), .DEPTH(R)) u_de_centre (
      .PClk(PClk), .Rst_n(Rst_n), .d(de2), .q(de_c));
   hsv_binary_filter_delay_line #(.WIDTH(1), .DEPTH(R + 1)) u_raw (
      .PClk(PClk), .Rst_n(Rst_n), .d(match), .q(Binary_Raw));
   hsv_binary_filter_delay_line #(.WIDTH(25), .DEPTH(L)) u_ctr (
      .PClk(PClk), .Rst_n(Rst_n), .d({VtcVCnt, VtcHCnt, VtcDe}), .q(ctr_o));
   assign {VtcVCnt_o, VtcHCnt_o, VtcDe_o} = ctr_o;
endmodule

// File: tb/tb_hsv_binary_filter.sv
// tb_hsv_binary_filter: scoreboard bench for hsv_binary_filter against a per-line reference model
module tb_hsv_binary_filter;
   localparam int NCOL = 16, HB = 4, NROW = 6, VB = 2, LINE = NCOL + HB, R = 1, L = 3 + R;
   localparam logic [23:0] NONE = 24'hFFFFFF, A = {8'd100, 8'd150, 8'd200}, B = {8'd3, 8'd150, 8'd200};
   localparam logic [23:0] C = {8'd50, 8'd100, 8'd100}, N = 24'h000000;
   typedef struct {logic raw; logic post; logic [11:0] h; logic [11:0] v; int t;} exp_t;
   logic PClk = 0, Rst_n = 1, VtcDe = 0;
   logic [11:0] VtcHCnt = 0, VtcVCnt = 0;
   logic [23:0] HSV24 = 0, HSV_detect = NONE;
   logic Binary_Raw, Binary_PostProcess, VtcDe_o;
   logic [11:0] VtcHCnt_o, VtcVCnt_o;
   exp_t sb[$];
   exp_t e;
   logic [23:0] pix [NROW][NCOL];
   int cyc = 0, tests = 0, fails = 0;
   bit run = 0;
   hsv_binary_filter dut (
      .PClk(PClk), .Rst_n(Rst_n), .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .VtcDe(VtcDe),
      .HSV24(HSV24), .HSV_detect(HSV_detect), .Binary_Raw(Binary_Raw),
      .Binary_PostProcess(Binary_PostProcess), .VtcHCnt_o(VtcHCnt_o), .VtcVCnt_o(VtcVCnt_o),
      .VtcDe_o(VtcDe_o));
   always #5 PClk = ~PClk;
   always @(posedge PClk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask
   function automatic bit model_match(input logic [23:0] p, input logic [23:0] r);
      int dh, ds, dv;
      if (r == NONE) return 0;
      dh = int'(p[23:16]) - int'(r[23:16]);
      dh = dh < 0 ? -dh : dh;
      dh = dh > 128 ? 256 - dh : dh;
      ds = int'(p[15:8]) - int'(r[15:8]);
      ds = ds < 0 ? -ds : ds;
      dv = int'(p[7:0]) - int'(r[7:0]);
      dv = dv < 0 ? -dv : dv;
      return dh <= 8 && ds <= 40 && dv <= 60;
   endfunction
   function automatic logic [23:0] near(input logic [23:0] r);
      return {8'(int'(r[23:16]) + int'($urandom_range(24)) - 12),
              8'(int'(r[15:8]) + int'($urandom_range(100)) - 50),
              8'(int'(r[7:0]) + int'($urandom_range(140)) - 70)};
   endfunction
   task automatic fill(input logic [23:0] r);
      for (int v = 0; v < NROW; v++)
         for (int c = 0; c < NCOL; c++) pix[v][c] = ($urandom_range(3) != 0) ? near(r) : 24'($urandom);
   endtask
   task automatic clear_line(input int v);
      for (int c = 0; c < NCOL; c++) pix[v][c] = N;
   endtask
   task automatic drive(input int h, input int v, input logic de, input logic [23:0] px, input logic [23:0] det);
      @(posedge PClk);
      #1;
      VtcHCnt = 12'(h);
      VtcVCnt = 12'(v);
      VtcDe = de;
      HSV24 = px;
      HSV_detect = det;
   endtask
   // r0 is presented until line sw, r1 afterwards; optional async reset pulse at (rv, rc)
   task automatic run_frame(input logic [23:0] r0, input logic [23:0] r1, input int sw, input int rv, input int rc);
      logic [23:0] mref;
      bit m [NCOL];
      bit f [NCOL];
      bit zero;
      int cnt;
      bit de;
      mref = sw > 0 ? r0 : r1;
      zero = 0;
      for (int v = 0; v < NROW + VB; v++) begin
         for (int c = 0; c < NCOL; c++) m[c] = v < NROW && model_match(pix[v][c], mref);
         for (int c = 0; c < NCOL; c++) begin
            cnt = 0;
            for (int j = c - R; j <= c + R; j++) if (j >= 0 && j < NCOL && m[j]) cnt++;
            f[c] = cnt >= R + 1;
         end
         for (int h = 0; h < LINE; h++) begin
            de = v < NROW && h < NCOL;
            drive(h, v, de, de ? pix[v][h] : 24'($urandom), v < sw ? r0 : r1);
            if (v == rv && h == rc) begin
               #2 Rst_n = 0;
               #1;
               chk("reset raw", Binary_Raw, 0);
               chk("reset post", Binary_PostProcess, 0);
               chk("reset de_o", VtcDe_o, 0);
               chk("reset hcnt_o", VtcHCnt_o, 0);
               chk("reset vcnt_o", VtcVCnt_o, 0);
               #2 Rst_n = 1;
               sb.delete();
               mref = NONE;
               zero = 1;
            end
            if (de) sb.push_back('{zero ? 1'b0 : m[h], zero ? 1'b0 : f[h], 12'(h), 12'(v), cyc});
         end
         zero = 0;
      end
   endtask
   always @(negedge PClk)
      if (run && Rst_n) begin
         if (VtcDe_o) begin
            if (sb.size() == 0) chk("unexpected output", 1, 0);
            else begin
               e = sb.pop_front();
               chk($sformatf("raw v%0d h%0d", e.v, e.h), Binary_Raw, e.raw);
               chk($sformatf("post v%0d h%0d", e.v, e.h), Binary_PostProcess, e.post);
               chk($sformatf("hcnt v%0d h%0d", e.v, e.h), VtcHCnt_o, e.h);
               chk($sformatf("vcnt v%0d h%0d", e.v, e.h), VtcVCnt_o, e.v);
               chk($sformatf("latency v%0d h%0d", e.v, e.h), cyc - e.t, L);
            end
         end else begin
            chk("raw while idle", Binary_Raw, 0);
            chk("post while idle", Binary_PostProcess, 0);
         end
      end
   initial begin
      #1 Rst_n = 0;
      #2;
      chk("init raw", Binary_Raw, 0);
      chk("init post", Binary_PostProcess, 0);
      chk("init de_o", VtcDe_o, 0);
      chk("init hcnt_o", VtcHCnt_o, 0);
      repeat (2) @(posedge PClk);
      #3 Rst_n = 1;
      run = 1;
      fill(A);
      run_frame(NONE, NONE, 99, -1, -1);
      fill(A);
      clear_line(0);
      pix[0][2] = {8'd106, 8'd180, 8'd150};
      pix[0][6] = {8'd109, 8'd180, 8'd150};
      pix[0][10] = {8'd100, 8'd191, 8'd200};
      pix[0][13] = {8'd100, 8'd150, 8'd140};
      run_frame(A, A, 99, -1, -1);
      fill(B);
      clear_line(0);
      pix[0][2] = {8'd252, 8'd150, 8'd200};
      pix[0][6] = {8'd250, 8'd150, 8'd200};
      pix[0][10] = {8'd11, 8'd150, 8'd200};
      run_frame(B, B, 99, -1, -1);
      fill(A);
      for (int v = 0; v < 4; v++) clear_line(v);
      pix[0][2] = A;
      pix[0][5] = A;
      pix[0][7] = A;
      pix[0][10] = A;
      pix[0][11] = A;
      pix[1][15] = A;
      pix[2][0] = A;
      pix[3][0] = A;
      pix[3][1] = A;
      pix[3][14] = A;
      pix[3][15] = A;
      run_frame(A, A, 99, -1, -1);
      fill(A);
      run_frame(A, C, 3, -1, -1);
      fill(C);
      run_frame(C, C, 99, -1, -1);
      for (int k = 0; k < 4; k++) begin
         logic [23:0] r;
         r = ($urandom_range(4) == 0) ? NONE : 24'($urandom);
         fill(r);
         run_frame(r, r, 99, -1, -1);
      end
      fill(A);
      run_frame(A, A, 99, 2, 8);
      fill(A);
      run_frame(A, A, 99, -1, -1);
      repeat (L + 4) drive(LINE, NROW + VB, 1'b0, 24'($urandom), A);
      chk("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hsv_binary_filter.md
Name: hsv_binary_filter

Overview:
- Per-pixel colour segmentation stage, directly upstream of color_detect.
- Compares the live HSV24 stream against the extracted reference colour HSV_detect using per-channel tolerances, giving a raw binary mask.
- Cleans the mask with a horizontal majority filter and drives Binary_PostProcess, which color_detect counts into Binary_Sum.
- Outputs and delayed timing counters are mutually cycle-aligned.

Parameters:
- H_TOL, 8, max circular hue distance that counts as a match (0..128)
- S_TOL, 40, max |S - S_ref| that counts as a match
- V_TOL, 60, max |V - V_ref| that counts as a match
- R, 1, majority-filter radius; window W = 2R+1 pixels (R in 1..3)

Ports:
- PClk  in  1  pixel clock
- Rst_n  in  1  asynchronous active-low reset
- VtcHCnt  in  12  horizontal pixel counter
- VtcVCnt  in  12  vertical line counter
- VtcDe  in  1  active-video flag, aligned with HSV24
- HSV24  in  24  pixel {H[23:16], S[15:8], V[7:0]}
- HSV_detect  in  24  reference colour; 24'hFFFFFF means none selected
- Binary_Raw  out  1  unfiltered match, delayed to align with Binary_PostProcess
- Binary_PostProcess  out  1  majority-filtered match
- VtcHCnt_o  out  12  VtcHCnt delayed by L
- VtcVCnt_o  out  12  VtcVCnt delayed by L
- VtcDe_o  out  1  VtcDe delayed by L

Behaviour:
- Reset (async, Rst_n=0):
  - All outputs 0, all pipeline and window registers 0.
  - Reference latch = 24'hFFFFFF (invalid).
  - Reset mid-frame: outputs drop to 0 immediately; first valid mask is the next frame after release.
- Reference latch:
  - HSV_detect is sampled only when VtcVCnt==0 && VtcHCnt==0.
  - Changes mid-frame take effect on the next frame.
  - ref_valid = (latched ref != 24'hFFFFFF).
- Stage 1 (registered): 8-bit absolute differences dh, ds, dv.
  - Hue is circular: if |H - Href| > 128 then dh = 256 - |H - Href|, computed in 9 bits and truncated to 8.
- Stage 2 (registered): match = VtcDe_d2 & ref_valid & (dh <= H_TOL) & (ds <= S_TOL) & (dv <= V_TOL). Comparisons are inclusive.
- Majority window:
  - W-bit shift register fed by match each cycle while the delayed DE is high.
  - Cleared to 0 on the cycle DE is low, so taps never span two lines.
  - Taps beyond the line start or end count as 0.
  - Window is centred on the pixel delayed R cycles.
  - Filtered bit = (popcount(window) >= R+1) & centre-tap DE; registered.
- Latency:
  - L = 3 + R cycles from HSV24/counters in to all outputs (4 at default).
  - Binary_Raw is the match delayed to the same L.
  - Counters and DE use an L-deep delay line.
- Line edge: the last R pixels of a line are evaluated as the window drains, while DE is still high in the delay line. No output bit is produced while the delayed DE is low.
- Throughput: one pixel per clock, no stalls, no back-pressure.

Decomposition:
- Shared package holds:
  - HSV_NONE = 24'hFFFFFF
  - HSV field index constants (H_MSB..V_LSB)
  - default tolerances
- One natural sub-module: delay_line (parameterised width and depth). It is used for the counter/DE alignment and the Binary_Raw alignment.

Test Plan:
1. Reference latched as 24'hFFFFFF, full frame of any pixels -> Binary_Raw = Binary_PostProcess = 0 for every pixel; VtcDe_o equals VtcDe delayed 4 cycles.
2. Ref {100,150,200}: pixel {106,180,150} -> Raw 1. Pixel {109,180,150} -> Raw 0 (dh=9). Pixel {100,191,200} -> Raw 0 (ds=41).
3. Hue wrap with ref H=3: pixel H=252 -> dh=7 -> Raw 1. Pixel H=250 -> dh=9 -> Raw 0. Pixel H=11 -> dh=8 -> Raw 1.
4. Filter, R=1, matches within one line:
   - Pattern 0,1,0 -> Post 0 at the centre.
   - Pattern 1,0,1 -> Post 1 at the centre (gap filled).
   - Run of 2 matches -> Post 1 on both.
   - Each output appears exactly 4 cycles after input.
5. Line boundary: match only at the last active column of line n and the first column of line n+1 -> Post 0 on both (window cleared during blanking).
6. Reference switch: HSV_detect changes at VtcVCnt=100 -> masks for lines 100..479 still use the old reference; the new reference applies from the next frame. Rst_n pulse mid-line -> outputs 0 the same cycle.
